// File: rtl/tetris_grid_reader_pkg.sv
// Shared definitions for the Tetris playfield reader: grid geometry used by the
// game-logic block and the frame FSM state encoding.
package tetris_grid_reader_pkg;

  localparam int GRID_ROWS = 20;
  localparam int GRID_COLS = 10;
  localparam int LINES_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/tetris_grid_reader_if.sv
// Row stream from the grid reader to the display driver or CPU bridge:
// valid/ready handshake carrying one playfield row and its index per transfer.
interface tetris_grid_reader_if
  import tetris_grid_reader_pkg::*;
#(
  parameter int COLS      = GRID_COLS,
  parameter int ROW_IDX_W = 5
);

  logic [COLS-1:0]      row_data;
  logic [ROW_IDX_W-1:0] row_idx;
  logic                 row_valid;
  logic                 row_ready;

  modport master (
    output row_data,
    output row_idx,
    output row_valid,
    input  row_ready
  );

  modport slave (
    input  row_data,
    input  row_idx,
    input  row_valid,
    output row_ready
  );

endinterface

// File: rtl/tetris_grid_reader_edge_counter_sat.sv
// Rising-edge detector on a level input feeding a saturating event counter;
// used for the cleared-row tally.
module tetris_grid_reader_edge_counter_sat
  import tetris_grid_reader_pkg::*;
#(
  parameter int CNT_W = LINES_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             level,
  output logic [CNT_W-1:0] count
);

  logic level_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      level_p1 <= 1'b0;
      count    <= '0;
    end else begin
      level_p1 <= level;
      if (level && !level_p1) begin
        count <= sat_inc(count);
      end
    end
  end

endmodule

// File: rtl/tetris_grid_reader.sv
// Snapshot-and-stream reader for the flattened playfield. Define GRID_DIFF_EN to
// keep a previous-frame copy and skip rows that have not changed since it.
module tetris_grid_reader
  import tetris_grid_reader_pkg::*;
#(
  parameter int ROWS      = GRID_ROWS,
  parameter int COLS      = GRID_COLS,
  parameter int ROW_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ROWS*COLS-1:0] grid_state,
  input  logic                 row_cleared,
  input  logic                 frame_start,
  tetris_grid_reader_if.master rows,
  output logic                 frame_done,
  output logic                 busy,
  output logic [LINES_W-1:0]   lines_cleared
);

  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(ROWS - 1);

  state_e               state;
  logic [ROW_IDX_W-1:0] ptr;
  logic [ROW_IDX_W-1:0] ptr_nxt;
  logic [COLS-1:0]      snap [ROWS];
  logic [COLS-1:0]      cap_row;
  logic [COLS-1:0]      row_nxt;
  logic                 cap_send;
  logic                 nxt_send;
  logic                 advance;
  logic                 row_valid_q;
  logic [COLS-1:0]      row_data_q;
  logic [ROW_IDX_W-1:0] row_idx_q;

  assign cap_row = grid_state[COLS-1:0];
  assign ptr_nxt = (ptr == LAST_ROW) ? '0 : ptr + 1'b1;
  assign row_nxt = snap[ptr_nxt];
  // A cycle with row_valid low inside SEND is a skipped row and always moves on.
  assign advance = row_valid_q ? rows.row_ready : 1'b1;

`ifdef GRID_DIFF_EN
  logic [COLS-1:0] prev [ROWS];
  logic            prev_valid;

  function automatic logic row_changed(input logic [COLS-1:0] cur,
                                       input logic [COLS-1:0] old,
                                       input logic            old_ok);
    return !(old_ok && (cur == old));
  endfunction

  assign cap_send = row_changed(cap_row, prev[0], prev_valid);
  assign nxt_send = row_changed(row_nxt, prev[ptr_nxt], prev_valid);
`else
  assign cap_send = 1'b1;
  assign nxt_send = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      row_valid_q <= 1'b0;
      row_data_q  <= '0;
      row_idx_q   <= '0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        snap[r] <= '0;
      end
`ifdef GRID_DIFF_EN
      for (int r = 0; r < ROWS; r++) begin
        prev[r] <= '0;
      end
      prev_valid <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            for (int r = 0; r < ROWS; r++) begin
              snap[r] <= grid_state[r*COLS +: COLS];
            end
            ptr         <= '0;
            row_valid_q <= cap_send;
            row_data_q  <= cap_row;
            row_idx_q   <= '0;
            busy        <= 1'b1;
            state       <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (advance) begin
            if (ptr == LAST_ROW) begin
              row_valid_q <= 1'b0;
              frame_done  <= 1'b1;
              state       <= ST_DONE;
            end else begin
              ptr         <= ptr_nxt;
              row_valid_q <= nxt_send;
              row_data_q  <= row_nxt;
              row_idx_q   <= ptr_nxt;
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
`ifdef GRID_DIFF_EN
          for (int r = 0; r < ROWS; r++) begin
            prev[r] <= snap[r];
          end
          prev_valid <= 1'b1;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rows.row_valid = row_valid_q;
  assign rows.row_data  = row_data_q;
  assign rows.row_idx   = row_idx_q;

  tetris_grid_reader_edge_counter_sat #(
    .CNT_W(LINES_W)
  ) u_edge_counter_sat (
    .clk  (clk),
    .reset(reset),
    .level(row_cleared),
    .count(lines_cleared)
  );

endmodule
